// File: rtl/multicycle_cu.sv
// Multicycle RV32I control unit: steps one instruction through fetch/decode/execute over a shared memory and ALU.
// Outputs are decoded from the registered state. Enables are further gated by mem_ready, the branch flags and rst.
module multicycle_cu #(
  parameter int ALU_CTRL_W  = 4,
  parameter int BRANCH_FULL = 1,
  parameter int WAIT_MEM    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  RegWrite,
  output logic                  retire,
  output logic                  illegal,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       ready;
  logic       br_ok;
  logic       br_cond;
  logic       taken;
  logic [3:0] alu_funct;
  logic [3:0] alu_op;
  logic       pc_we, ir_we, mem_we, reg_we, retire_raw;

  assign ready = (WAIT_MEM != 0) ? mem_ready : 1'b1;

  // funct3 010/011 never encode a branch; the reduced set keeps only beq/bne.
  assign br_ok = (funct3[2:1] == 2'b00) || ((BRANCH_FULL != 0) && funct3[2]);

  always_comb begin
    case (funct3[2:1])
      2'b00:   br_cond = zero;
      2'b10:   br_cond = lt;
      2'b11:   br_cond = ltu;
      default: br_cond = zero;
    endcase
    taken = br_cond ^ funct3[0];
  end

  always_comb begin
    case (op)
      OP_LOAD, OP_I: ImmSrc = 3'b000;
      OP_STORE:      ImmSrc = 3'b001;
      OP_BR:         ImmSrc = 3'b010;
      OP_JAL:        ImmSrc = 3'b011;
      OP_LUI:        ImmSrc = 3'b100;
      default:       ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  alu_funct = (op == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_funct = ALU_SLL;
      3'b010:  alu_funct = ALU_SLT;
      3'b011:  alu_funct = ALU_SLTU;
      3'b100:  alu_funct = ALU_XOR;
      3'b101:  alu_funct = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_funct = ALU_OR;
      default: alu_funct = ALU_AND;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    retire_raw = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = ready;
        pc_we     = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/jal target
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BR:             state_d = br_ok ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_we     = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_we     = 1'b1;
        retire_raw = ready;
        if (ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = alu_funct;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = alu_funct;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALU_SUB;
        pc_we      = taken;
        retire_raw = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // rst kills every write enable in the same cycle so a reset never leaves a partial write behind
  assign PCWrite    = pc_we & ~rst;
  assign IRWrite    = ir_we & ~rst;
  assign MemWrite   = mem_we & ~rst;
  assign RegWrite   = reg_we & ~rst;
  assign retire     = retire_raw & ~rst;
  assign ALUControl = ALU_CTRL_W'(alu_op);
  assign illegal    = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: queue-based instruction-step model with per-cycle compare, plus literal directed checks.
module tb_multicycle_cu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       rst, funct7_5, zero, lt, ltu, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ret, a_ill;
  logic [1:0] a_rs, a_sa, a_sb;
  logic [2:0] a_imm;
  logic [3:0] a_alu, a_st;

  logic       rst_b, mr_b;
  logic [6:0] op_b;
  logic [2:0] f3_b;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ret, b_ill;
  logic [1:0] b_rs, b_sa, b_sb;
  logic [2:0] b_imm;
  logic [5:0] b_alu;
  logic [3:0] b_st;

  multicycle_cu dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw),
    .ResultSrc(a_rs), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ImmSrc(a_imm),
    .ALUControl(a_alu), .RegWrite(a_rw), .retire(a_ret), .illegal(a_ill), .state(a_st)
  );

  multicycle_cu #(.ALU_CTRL_W(6), .BRANCH_FULL(0), .WAIT_MEM(0)) dut_b (
    .clk(clk), .rst(rst_b), .op(op_b), .funct3(f3_b), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mr_b),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw), .IRWrite(b_irw),
    .ResultSrc(b_rs), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ImmSrc(b_imm),
    .ALUControl(b_alu), .RegWrite(b_rw), .retire(b_ret), .illegal(b_ill), .state(b_st)
  );

  // bit0 PCWrite,1 AdrSrc,2 MemWrite,3 IRWrite,[5:4] ResultSrc,[7:6] SrcA,[9:8] SrcB,[12:10] Imm,[16:13] ALU,17 RegWrite,18 retire,19 illegal,[23:20] state
  wire [23:0] a_vec = {a_st, a_ill, a_ret, a_rw, a_alu, a_imm, a_sb, a_sa, a_rs, a_irw, a_mw, a_adr, a_pcw};
  // same order with a 6-bit ALU field: [18:13] ALU,19 RegWrite,20 retire,21 illegal,[25:22] state
  wire [25:0] b_vec = {b_st, b_ill, b_ret, b_rw, b_alu, b_imm, b_sb, b_sa, b_rs, b_irw, b_mw, b_adr, b_pcw};

  int          n_cmp = 0;
  int          n_fail = 0;
  int          seq[$];
  bit          rand_flags = 1'b1;
  int          trap_wait = 0;
  logic [23:0] obs[$];
  logic [25:0] obs_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] st(input int i);
    return obs[i][23:20];
  endfunction

  function automatic logic [3:0] st_b(input int i);
    return obs_b[i][25:22];
  endfunction

  // Remaining steps of an instruction once its opcode is known (state numbers).
  task automatic set_tail();
    case (op)
      OP_LOAD:  seq = {2, 3, 4};
      OP_STORE: seq = {2, 5};
      OP_R:     seq = {6, 8};
      OP_I:     seq = {7, 8};
      OP_BR:    if (funct3 == 3'd2 || funct3 == 3'd3) seq = {15}; else seq = {9};
      OP_JAL:   seq = {10, 8};
      OP_LUI:   seq = {11, 8};
      default:  seq = {15};
    endcase
  endtask

  task automatic model_step(input bit r, input bit mr);
    int cur = seq[0];
    if (r) begin
      seq = {0, 1};
      return;
    end
    if (cur == 15) return;
    if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
    if (cur == 1) set_tail();
    else void'(seq.pop_front());
    if (seq.size() == 0) seq = {0, 1};
  endtask

  function automatic logic [3:0] exec_alu(input bit rtype);
    logic [3:0] by_f3[8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    logic [3:0] r = by_f3[funct3];
    if (funct3 == 3'd0 && rtype && funct7_5) r = 4'd1;
    if (funct3 == 3'd5 && funct7_5) r = 4'd9;
    return r;
  endfunction

  function automatic logic [23:0] model_out();
    int s = seq[0];
    logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, ret = 1'b0, tk = 1'b0;
    logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00;
    logic [3:0] alu = 4'd0;
    logic [2:0] imm = 3'b000;
    if (op == OP_STORE) imm = 3'b001;
    if (op == OP_BR)    imm = 3'b010;
    if (op == OP_JAL)   imm = 3'b011;
    if (op == OP_LUI)   imm = 3'b100;
    case (funct3)
      3'd0: tk = zero;
      3'd1: tk = !zero;
      3'd4: tk = lt;
      3'd5: tk = !lt;
      3'd6: tk = ltu;
      3'd7: tk = !ltu;
      default: tk = 1'b0;
    endcase
    case (s)
      0:  begin sb = 2'b10; rs = 2'b10; irw = mem_ready; pcw = mem_ready; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; ret = mem_ready; end
      6:  begin sa = 2'b10; alu = exec_alu(1'b1); end
      7:  begin sa = 2'b10; sb = 2'b01; alu = exec_alu(1'b0); end
      8:  begin rw = 1'b1; ret = 1'b1; end
      9:  begin sa = 2'b10; alu = 4'd1; pcw = tk; ret = 1'b1; end
      10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      11: begin sa = 2'b11; sb = 2'b01; end
      default: ;
    endcase
    if (rst) begin
      pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ret = 1'b0;
    end
    return {4'(s), (s == 15), ret, rw, alu, imm, sb, sa, rs, irw, mw, adr, pcw};
  endfunction

  task automatic tick(input bit r, input bit mr);
    rst = r;
    mem_ready = mr;
    if (rand_flags) begin
      zero = 1'($urandom);
      lt   = 1'($urandom);
      ltu  = 1'($urandom);
    end
    #1;
    obs.push_back(a_vec);
    check("cycle", {8'h00, a_vec}, {8'h00, model_out()});
    @(posedge clk);
    model_step(r, mr);
    @(negedge clk);
  endtask

  task automatic tick_b();
    #1;
    obs_b.push_back(b_vec);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pick_instr();
    int k = $urandom_range(0, 19);
    logic [6:0] bad[4] = '{7'h00, 7'h7f, 7'b0010111, 7'b1100111};
    funct3   = 3'($urandom);
    funct7_5 = 1'($urandom);
    if (k < 3)       op = OP_R;
    else if (k < 6)  op = OP_I;
    else if (k < 8)  op = OP_LOAD;
    else if (k < 10) op = OP_STORE;
    else if (k < 14) op = OP_BR;
    else if (k < 16) op = OP_JAL;
    else if (k < 18) op = OP_LUI;
    else             op = bad[$urandom_range(0, 3)];
  endtask

  initial begin
    logic en_any;
    logic trap_ok;
    rst = 1'b1; rst_b = 1'b1; mr_b = 1'b0; mem_ready = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    op_b = 7'd0; f3_b = 3'd0;
    @(negedge clk);
    repeat (2) begin
      #1;
      check("rst_enables_a", {a_pcw, a_irw, a_mw, a_rw, a_ret}, 32'd0);
      check("rst_enables_b", {b_pcw, b_irw, b_mw, b_rw, b_ret}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("rst_state_a", {a_st, a_ill}, 32'd0);
    @(negedge clk);

    // Reduced instance: no memory wait, beq/bne only, 6-bit ALUControl.
    rst_b = 1'b0; zero = 1'b1; funct7_5 = 1'b1;
    op_b = OP_R;  f3_b = 3'b000; repeat (4) tick_b();
    op_b = OP_BR; f3_b = 3'b000; repeat (3) tick_b();
    op_b = OP_BR; f3_b = 3'b100; repeat (4) tick_b();
    rst_b = 1'b1; tick_b();
    rst_b = 1'b0; tick_b();
    check("b_r_states", {st_b(0), st_b(1), st_b(2), st_b(3)}, 32'h0168);
    check("b_nowait_irwrite", obs_b[0][3], 32'd1);
    check("b_sub_alu6", obs_b[2][18:13], 32'h01);
    check("b_r_regwrite", {obs_b[2][19], obs_b[3][19], obs_b[3][20]}, 32'b011);
    check("b_beq_states", {st_b(4), st_b(5), st_b(6)}, 32'h019);
    check("b_beq_taken", obs_b[6][0], 32'd1);
    check("b_blt_trap", {st_b(7), st_b(8), st_b(9), st_b(10)}, 32'h01FF);
    check("b_trap_illegal", obs_b[10][21], 32'd1);
    check("b_rst_clear", {st_b(12), obs_b[12][21]}, 32'd0);

    // Directed sequences on the full instance.
    seq = {0, 1};
    rand_flags = 1'b0;
    op = OP_R; funct3 = 3'b000; funct7_5 = 1'b1;
    repeat (4) tick(1'b0, 1'b1);
    op = OP_LOAD; funct3 = 3'b010; funct7_5 = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b1);
    op = OP_BR; funct3 = 3'b000; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    repeat (3) tick(1'b0, 1'b1);
    funct3 = 3'b100; lt = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    funct3 = 3'b111; lt = 1'b0; ltu = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    op = OP_JAL; funct3 = 3'b000;
    repeat (4) tick(1'b0, 1'b1);
    op = OP_STORE; funct3 = 3'b010;
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    op = 7'b0000000;
    repeat (12) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);

    check("a_r_states", {st(0), st(1), st(2), st(3)}, 32'h0168);
    check("a_sub_alu", obs[2][16:13], 32'd1);
    check("a_r_write", {obs[2][17], obs[2][18], obs[3][17], obs[3][18]}, 32'b0011);
    check("a_lw_states", {st(4), st(5), st(6), st(7), st(8), st(9), st(10)}, 32'h0123334);
    check("a_lw_adrsrc", {obs[7][1], obs[8][1], obs[9][1]}, 32'b111);
    check("a_lw_wb", {obs[10][5:4], obs[10][17]}, 32'b011);
    check("a_beq_not_taken", obs[13][0], 32'd0);
    check("a_blt_taken", obs[16][0], 32'd1);
    check("a_bgeu_not_taken", obs[19][0], 32'd0);
    check("a_jal_states", {st(20), st(21), st(22), st(23)}, 32'h01A8);
    check("a_jal_ctl", {obs[22][0], obs[22][7:6], obs[22][9:8]}, 32'b10110);
    check("a_jal_wb", obs[23][17], 32'd1);
    check("a_sw_rst", {st(27), obs[27][2], obs[27][18]}, 32'h14);
    check("a_sw_after_rst", {st(28), st(29)}, 32'h01);
    en_any = 1'b0;
    trap_ok = 1'b1;
    for (int i = 30; i < 40; i++) begin
      en_any  = en_any | obs[i][0] | obs[i][2] | obs[i][3] | obs[i][17] | obs[i][18];
      trap_ok = trap_ok & (st(i) == 4'hF) & obs[i][19];
    end
    check("a_trap_quiet", en_any, 32'd0);
    check("a_trap_held", trap_ok, 32'd1);
    check("a_trap_rst", {st(41), obs[41][19]}, 32'd0);

    // Randomized run against the step model.
    rand_flags = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      bit r;
      if (seq[0] == 0) pick_instr();
      if (seq[0] == 15) begin
        trap_wait++;
        r = (trap_wait > 4);
      end else begin
        r = ($urandom_range(0, 59) == 0);
      end
      if (r) trap_wait = 0;
      tick(r, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
